// File: rtl/i2s_frame_sequencer.sv
// i2s_frame_sequencer
// Deserializes an I2S stream (already strobed into the system clock domain)
// into stereo frames and presents them through a valid/ready handshake.
//
// Ports
//   Clock       system clock, rising edge
//   Reset       synchronous, active-high
//   BitStrobe   one-cycle pulse per serial bit clock rising edge
//   LRCLK       word select (0 = left, 1 = right), sampled on BitStrobe
//   SDATA       serial data, MSB first, sampled on BitStrobe
//   BitCount    bit position within the current channel word (0 = delay slot)
//   SampleL/R   last committed stereo frame
//   FrameValid  SampleL/SampleR hold an unconsumed frame
//   FrameReady  consumer accepts the frame
//   Overrun     sticky: a frame was overwritten before it was consumed
//   ShortWord   one-cycle pulse when a channel word ends early
module i2s_frame_sequencer #(
  parameter int SAMPLE_BITS = 24
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   BitStrobe,
  input  logic                   LRCLK,
  input  logic                   SDATA,
  output logic [4:0]             BitCount,
  output logic [SAMPLE_BITS-1:0] SampleL,
  output logic [SAMPLE_BITS-1:0] SampleR,
  output logic                   FrameValid,
  input  logic                   FrameReady,
  output logic                   Overrun,
  output logic                   ShortWord
);

  localparam logic [4:0] CNT_LAST   = 5'(SAMPLE_BITS);
  localparam logic [4:0] CNT_CAP    = 5'(SAMPLE_BITS + 1);
  localparam logic [4:0] CNT_COMMIT = 5'(SAMPLE_BITS + 2);

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

  state_t                 state_q, state_d;
  logic                   lr_prev_q, lr_prev_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic [SAMPLE_BITS-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_BITS-1:0] hold_r_q, hold_r_d;
  logic                   l_done_q, l_done_d;
  logic                   r_done_q, r_done_d;
  logic [SAMPLE_BITS-1:0] smp_l_q, smp_l_d;
  logic [SAMPLE_BITS-1:0] smp_r_q, smp_r_d;
  logic                   fv_q, fv_d;
  logic                   ovr_q, ovr_d;
  logic                   sw_q, sw_d;

  logic lr_edge, lr_rise, lr_fall, commit;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= SYNC;
      lr_prev_q <= 1'b1;
      cnt_q     <= '0;
      shift_q   <= '0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      l_done_q  <= 1'b0;
      r_done_q  <= 1'b0;
      smp_l_q   <= '0;
      smp_r_q   <= '0;
      fv_q      <= 1'b0;
      ovr_q     <= 1'b0;
      sw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lr_prev_q <= lr_prev_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      l_done_q  <= l_done_d;
      r_done_q  <= r_done_d;
      smp_l_q   <= smp_l_d;
      smp_r_q   <= smp_r_d;
      fv_q      <= fv_d;
      ovr_q     <= ovr_d;
      sw_q      <= sw_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lr_prev_d = lr_prev_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    l_done_d  = l_done_q;
    r_done_d  = r_done_q;
    smp_l_d   = smp_l_q;
    smp_r_d   = smp_r_q;
    fv_d      = fv_q;
    ovr_d     = ovr_q;
    sw_d      = 1'b0;
    commit    = 1'b0;

    lr_edge = lr_prev_q ^ LRCLK;
    lr_rise = ~lr_prev_q & LRCLK;
    lr_fall = lr_prev_q & ~LRCLK;

    if (BitStrobe) begin
      lr_prev_d = LRCLK;
      if (lr_edge)             cnt_d = '0;
      else if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;

      if (cnt_d >= 5'd1 && cnt_d <= CNT_LAST)
        shift_d = {shift_q[SAMPLE_BITS-2:0], SDATA};

      case (state_q)
        SYNC: if (lr_fall) state_d = LEFT;
        LEFT: begin
          if (lr_edge) begin
            if (lr_rise) state_d = RIGHT;
            // Word ended before its last bit was captured: drop the channel.
            if (cnt_q < CNT_CAP) begin
              sw_d     = 1'b1;
              l_done_d = 1'b0;
            end
          end else if (cnt_d == CNT_CAP) begin
            // No shift happens at CNT_CAP, so shift_q already holds the word.
            hold_l_d = shift_q;
            l_done_d = 1'b1;
          end
        end
        RIGHT: begin
          if (lr_edge) begin
            if (lr_fall) state_d = LEFT;
            if (cnt_q < CNT_CAP) begin
              sw_d     = 1'b1;
              r_done_d = 1'b0;
            end
          end else if (cnt_d == CNT_CAP) begin
            hold_r_d = shift_q;
            r_done_d = 1'b1;
          end else if (cnt_d == CNT_COMMIT) begin
            // Commit point: publish only a fully captured pair, then rearm.
            commit   = l_done_q & r_done_q;
            l_done_d = 1'b0;
            r_done_d = 1'b0;
          end
        end
        default: state_d = SYNC;
      endcase
    end

    // Handshake runs every cycle; a commit wins over a same-cycle accept.
    if (commit) begin
      smp_l_d = hold_l_q;
      smp_r_d = hold_r_q;
      fv_d    = 1'b1;
      if (fv_q && !FrameReady) ovr_d = 1'b1;
    end else if (fv_q && FrameReady) begin
      fv_d = 1'b0;
    end
  end

  assign BitCount   = cnt_q;
  assign SampleL    = smp_l_q;
  assign SampleR    = smp_r_q;
  assign FrameValid = fv_q;
  assign Overrun    = ovr_q;
  assign ShortWord  = sw_q;

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// tb_i2s_frame_sequencer
// Directed I2S word sequences with a word-level reference: the driver knows
// which words it sends and derives capture/commit/short-word events from
// that; a cycle model turns those events into expected outputs, which one
// compare process checks every cycle. Literal expectations pin key results.
module tb_i2s_frame_sequencer;
  localparam int SB = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          strobe = 1'b0;
  logic          lr = 1'b1;
  logic          sd = 1'b0;
  logic          rdy = 1'b0;
  logic [4:0]    bc_o;
  logic [SB-1:0] sl_o, sr_o;
  logic          fv_o, ovr_o, sw_o;

  i2s_frame_sequencer #(.SAMPLE_BITS(SB)) dut (
    .Clock(clk), .Reset(rst), .BitStrobe(strobe), .LRCLK(lr), .SDATA(sd),
    .BitCount(bc_o), .SampleL(sl_o), .SampleR(sr_o), .FrameValid(fv_o),
    .FrameReady(rdy), .Overrun(ovr_o), .ShortWord(sw_o)
  );

  always #5 clk = ~clk;

  // Word-level bookkeeping (driver only)
  logic          b_prev = 1'b1;
  int            b_bc = 0;
  logic          b_synced = 1'b0, b_lok = 1'b0, b_rok = 1'b0;
  logic [SB-1:0] b_capL = '0, b_capR = '0, cur_data = '0;
  logic          rdy_base = 1'b0, ready_on_commit = 1'b0;

  // Events handed to the cycle model for the strobe being driven
  logic [4:0]    ev_bc = '0;
  logic          ev_sw = 1'b0, ev_commit = 1'b0;
  logic [SB-1:0] ev_L = '0, ev_R = '0;

  // Cycle model
  logic [4:0]    m_bc;
  logic [SB-1:0] m_L, m_R;
  logic          m_fv, m_ovr, m_sw;

  always @(posedge clk) begin
    if (rst) begin
      m_bc <= '0; m_L <= '0; m_R <= '0; m_fv <= 1'b0; m_ovr <= 1'b0; m_sw <= 1'b0;
    end else begin
      m_sw <= strobe && ev_sw;
      if (strobe) m_bc <= ev_bc;
      if (strobe && ev_commit) begin
        m_L <= ev_L; m_R <= ev_R; m_fv <= 1'b1;
        if (m_fv && !rdy) m_ovr <= 1'b1;
      end else if (m_fv && rdy) begin
        m_fv <= 1'b0;
      end
    end
  end

  // Compare process (sole owner of the counters)
  int            n_chk = 0, n_fail = 0;
  int            rise_cnt = 0, sw_cnt = 0;
  logic          fv_prev = 1'b0;
  logic [SB-1:0] seenL = '0, seenR = '0;
  logic          chk_en = 1'b0;
  logic          lit_go = 1'b0;
  string         lit_name = "";
  logic [31:0]   lit_act = '0, lit_exp = '0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("BitCount",   32'(bc_o),  32'(m_bc));
      cmp("FrameValid", 32'(fv_o),  32'(m_fv));
      cmp("SampleL",    32'(sl_o),  32'(m_L));
      cmp("SampleR",    32'(sr_o),  32'(m_R));
      cmp("Overrun",    32'(ovr_o), 32'(m_ovr));
      cmp("ShortWord",  32'(sw_o),  32'(m_sw));
      if (fv_o === 1'b1 && fv_prev !== 1'b1) begin
        rise_cnt++; seenL = sl_o; seenR = sr_o;
      end
      fv_prev = fv_o;
      if (sw_o === 1'b1) sw_cnt++;
    end
    if (lit_go) cmp(lit_name, lit_act, lit_exp);
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    @(posedge clk); #1;
    lit_name = nm; lit_act = act; lit_exp = exp; lit_go = 1'b1;
    @(negedge clk); #1;
    lit_go = 1'b0;
  endtask

  task automatic drive_bit(input logic l, input logic d);
    logic edge_s, short_s;
    edge_s  = (l != b_prev);
    short_s = b_synced && edge_s && (b_bc < SB + 1);
    if (edge_s) b_bc = 0; else if (b_bc < 31) b_bc++;
    ev_sw = short_s; ev_commit = 1'b0;
    if (short_s) begin
      if (b_prev == 1'b0) b_lok = 1'b0; else b_rok = 1'b0;
    end
    if (!b_synced && edge_s && l == 1'b0) b_synced = 1'b1;
    if (b_synced && l == 1'b0 && b_bc == SB + 1) begin b_lok = 1'b1; b_capL = cur_data; end
    if (b_synced && l == 1'b1 && b_bc == SB + 1) begin b_rok = 1'b1; b_capR = cur_data; end
    if (b_synced && l == 1'b1 && b_bc == SB + 2) begin
      if (b_lok && b_rok) begin ev_commit = 1'b1; ev_L = b_capL; ev_R = b_capR; end
      b_lok = 1'b0; b_rok = 1'b0;
    end
    b_prev = l;
    ev_bc  = 5'(b_bc);
    @(posedge clk); #1;
    strobe = 1'b1; lr = l; sd = d;
    rdy = (ev_commit && ready_on_commit) ? 1'b1 : rdy_base;
    @(posedge clk); #1;
    strobe = 1'b0; sd = 1'($urandom); rdy = rdy_base;
  endtask

  // One channel word of n strobes: delay slot, SB data bits MSB first, junk.
  task automatic send_word(input logic l, input logic [SB-1:0] data, input int n);
    cur_data = data;
    for (int k = 0; k < n; k++)
      drive_bit(l, (k >= 1 && k <= SB) ? data[SB-k] : 1'($urandom));
  endtask

  task automatic do_reset(input logic l);
    @(posedge clk); #1;
    rst = 1'b1; strobe = 1'b1; lr = l; sd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; strobe = 1'b0;
    b_prev = 1'b1; b_bc = 0; b_synced = 1'b0; b_lok = 1'b0; b_rok = 1'b0;
    ev_sw = 1'b0; ev_commit = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      strobe = 1'b0; rdy = rdy_base;
    end
  endtask

  initial begin
    // Reset while released with LRCLK=1 mid-right-word; strobe held during reset
    do_reset(1'b1);
    chk_en = 1'b1;
    lit("reset_fv", 32'(fv_o), 32'd0);
    lit("reset_bc", 32'(bc_o), 32'd0);
    lit("reset_ovr", 32'(ovr_o), 32'd0);
    lit("reset_sl", 32'(sl_o), 32'd0);

    // Partial right word in SYNC, then a clean 32-bit frame with FrameReady=1
    rdy_base = 1'b1;
    send_word(1'b1, 24'h0F0F0F, 10);
    send_word(1'b0, 24'hA5A5A5, 32);
    lit("no_frame_before_pair", 32'(rise_cnt), 32'd0);
    send_word(1'b1, 24'h5A5A5A, 32);
    lit("frame1_count", 32'(rise_cnt), 32'd1);
    lit("frame1_L", 32'(seenL), 32'hA5A5A5);
    lit("frame1_R", 32'(seenR), 32'h5A5A5A);

    // Two frames without FrameReady -> overrun, second frame presented
    rdy_base = 1'b0;
    idle(2);
    send_word(1'b0, 24'h123456, 32);
    send_word(1'b1, 24'h654321, 32);
    send_word(1'b0, 24'hABCDEF, 32);
    send_word(1'b1, 24'hFEDCBA, 32);
    lit("ovr_set", 32'(ovr_o), 32'd1);
    lit("ovr_fv", 32'(fv_o), 32'd1);
    lit("ovr_L", 32'(sl_o), 32'hABCDEF);
    lit("ovr_R", 32'(sr_o), 32'hFEDCBA);

    // Reset in the middle of a left word discards everything
    send_word(1'b0, 24'h111111, 12);
    do_reset(1'b0);
    lit("midreset_ovr", 32'(ovr_o), 32'd0);
    lit("midreset_fv", 32'(fv_o), 32'd0);

    // Accept in the same cycle as the next commit
    send_word(1'b0, 24'h2468AC, 32);
    send_word(1'b1, 24'h13579B, 32);
    ready_on_commit = 1'b1;
    send_word(1'b0, 24'h0C0FFE, 32);
    send_word(1'b1, 24'h0BEEF1, 32);
    ready_on_commit = 1'b0;
    lit("hs_fv", 32'(fv_o), 32'd1);
    lit("hs_L", 32'(sl_o), 32'h0C0FFE);
    lit("hs_R", 32'(sr_o), 32'h0BEEF1);
    lit("hs_ovr", 32'(ovr_o), 32'd0);

    // Truncated left word: one ShortWord, frame skipped, next frame commits
    rdy_base = 1'b1;
    idle(4);
    send_word(1'b0, 24'h777777, 21);
    send_word(1'b1, 24'h888888, 32);
    lit("short_pulses", 32'(sw_cnt), 32'd1);
    lit("short_no_commit", 32'(rise_cnt), 32'd3);
    send_word(1'b0, 24'h31415A, 32);
    send_word(1'b1, 24'h27182B, 32);
    lit("after_short_count", 32'(rise_cnt), 32'd4);
    lit("after_short_L", 32'(seenL), 32'h31415A);
    lit("after_short_R", 32'(seenR), 32'h27182B);

    // No strobes for 100 cycles: everything holds
    idle(100);
    lit("idle_bc", 32'(bc_o), 32'd31);
    lit("idle_sr", 32'(sr_o), 32'h27182B);
    lit("idle_fv", 32'(fv_o), 32'd0);
    lit("idle_ovr", 32'(ovr_o), 32'd0);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
